// File: rtl/dcache_data_array.sv
// N-way set-associative dcache data store: byte-strobed CPU stores, loads with 1-cycle latency,
// sequenced refill (refill_ready) and writeback (wb_valid/wb_ready, holds while stalled) bursts.
module dcache_data_array #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_hold,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [DATA_W/8-1:0]       req_wstrb,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [WAYS-1:0]           hit_way,
    output logic                      rdata_valid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    input  logic                      refill_start,
    input  logic [$clog2(WAYS)-1:0]   refill_way,
    input  logic [$clog2(SETS)-1:0]   refill_index,
    input  logic                      refill_valid,
    input  logic [DATA_W-1:0]         refill_data,
    output logic                      refill_ready,
    output logic                      refill_done,
    input  logic                      wb_start,
    input  logic [$clog2(WAYS)-1:0]   wb_way,
    input  logic [$clog2(SETS)-1:0]   wb_index,
    output logic                      wb_valid,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      wb_last,
    input  logic                      wb_ready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LA_W   = IDX_W + WORD_W;
    localparam logic [WORD_W-1:0] LAST  = WORD_W'(LINE_WORDS - 1);
    localparam logic [WORD_W-1:0] WORD0 = '0;

    typedef enum logic [1:0] {IDLE, REFILL, WB} state_t;

    state_t            state;
    logic [WORD_W-1:0] cnt;
    logic [WAY_W-1:0]  way_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ld_vld;
    logic [WAYS-1:0]   ld_sel;

    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic [LA_W-1:0]   req_line;
    logic [LA_W-1:0]   rf_addr;
    logic [LA_W-1:0]   wb_addr;
    logic [WORD_W-1:0] cnt_nxt;
    logic [WAYS-1:0]   hit_sel;
    logic              idle;
    logic              wb_go;
    logic              req_ok;
    logic              ld_go;
    logic              ld_re;
    logic              st_go;
    logic              rf_beat;
    logic              wb_fire;
    logic              wb_step;
    logic              unused_addr;

    logic [DATA_W-1:0] ld_dat [WAYS];
    logic [DATA_W-1:0] wb_dat [WAYS];

    assign req_idx     = req_addr[OFF_W+WORD_W +: IDX_W];
    assign req_word    = req_addr[OFF_W +: WORD_W];
    assign unused_addr = ^{req_addr[ADDR_W-1:LA_W+OFF_W], req_addr[OFF_W-1:0]};
    assign req_line    = {req_idx, req_word};
    assign cnt_nxt     = cnt + WORD_W'(1);
    assign rf_addr     = {idx_q, cnt};

    // Lowest set hit bit wins when the tag compare reports several.
    assign hit_sel = hit_way & (~hit_way + WAYS'(1));

    // A writeback start claims the array port, so a same-cycle CPU request is dropped.
    assign idle    = (state == IDLE);
    assign wb_go   = idle & wb_start;
    assign req_ok  = idle & ~wb_start & req_valid;
    assign ld_go   = req_ok & ~req_we & (|hit_way);
    assign ld_re   = req_ok & ~req_we & ~stall_hold;
    assign st_go   = req_ok & req_we;
    assign rf_beat = (state == REFILL) & refill_valid;
    assign wb_fire = (state == WB) & wb_valid & wb_ready;
    assign wb_step = wb_fire & (cnt != LAST);
    assign wb_addr = wb_go ? {wb_index, WORD0} : {idx_q, cnt_nxt};

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [DATA_W-1:0] mem [SETS*LINE_WORDS];
        logic [LA_W-1:0]   addr;
        logic              we;
        logic              wb_re;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdat;
        logic [DATA_W-1:0] ld_q;
        logic [DATA_W-1:0] wb_q;

        assign wb_re = (wb_go & (wb_way == WAY_W'(w))) | (wb_step & (way_q == WAY_W'(w)));

        always_comb begin
            addr = req_line;
            we   = st_go & hit_sel[w];
            strb = req_wstrb;
            wdat = req_wdata;
            if (wb_re) begin
                addr = wb_addr;
            end else if (state == REFILL) begin
                addr = rf_addr;
                we   = rf_beat & (way_q == WAY_W'(w));
                strb = '1;
                wdat = refill_data;
            end
        end

        always_ff @(posedge clk) begin
            if (we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (strb[b]) mem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end

        // Separate load and writeback capture registers keep rdata frozen under stall_hold
        // even while a writeback burst is reading the same port.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ld_q <= '0;
                wb_q <= '0;
            end else begin
                if (ld_re) ld_q <= mem[addr];
                if (wb_re) wb_q <= mem[addr];
            end
        end

        assign ld_dat[w] = ld_q;
        assign wb_dat[w] = wb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_vld <= 1'b0;
            ld_sel <= '0;
        end else if (!stall_hold) begin
            ld_vld <= ld_go;
            ld_sel <= hit_sel;
        end
    end

    always_comb begin
        rdata = '0;
        if (ld_vld) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ld_sel[w]) rdata = rdata | ld_dat[w];
            end
        end
    end

    assign rdata_valid = ld_vld;
    assign wb_data     = wb_valid ? wb_dat[way_q] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            way_q        <= '0;
            idx_q        <= '0;
            busy         <= 1'b0;
            refill_ready <= 1'b0;
            refill_done  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_last      <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_start) begin
                        state    <= WB;
                        cnt      <= '0;
                        way_q    <= wb_way;
                        idx_q    <= wb_index;
                        busy     <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_last  <= (LAST == WORD0);
                    end else if (refill_start) begin
                        state        <= REFILL;
                        cnt          <= '0;
                        way_q        <= refill_way;
                        idx_q        <= refill_index;
                        busy         <= 1'b1;
                        refill_ready <= 1'b1;
                    end
                end
                REFILL: begin
                    if (refill_valid) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            refill_ready <= 1'b0;
                            refill_done  <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            wb_valid <= 1'b0;
                            wb_last  <= 1'b0;
                        end else begin
                            wb_last <= (cnt_nxt == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_data_array.sv
// Directed bench for dcache_data_array: stimulus pushes expected load/writeback data, a negedge monitor checks it.
module tb_dcache_data_array;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_hold = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_wstrb = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  hit_way = '0;
    logic        rdata_valid;
    logic [63:0] rdata;
    logic        busy;
    logic        refill_start = 1'b0;
    logic [0:0]  refill_way = '0;
    logic [5:0]  refill_index = '0;
    logic        refill_valid = 1'b0;
    logic [63:0] refill_data = '0;
    logic        refill_ready;
    logic        refill_done;
    logic        wb_start = 1'b0;
    logic [0:0]  wb_way = '0;
    logic [5:0]  wb_index = '0;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        wb_last;
    logic        wb_ready = 1'b0;

    dcache_data_array #(.WAYS(2), .SETS(64), .LINE_WORDS(4), .DATA_W(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .stall_hold(stall_hold),
        .req_valid(req_valid), .req_we(req_we), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .hit_way(hit_way), .rdata_valid(rdata_valid), .rdata(rdata),
        .busy(busy), .refill_start(refill_start), .refill_way(refill_way),
        .refill_index(refill_index), .refill_valid(refill_valid), .refill_data(refill_data),
        .refill_ready(refill_ready), .refill_done(refill_done), .wb_start(wb_start),
        .wb_way(wb_way), .wb_index(wb_index), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_last(wb_last), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] dat; bit neq; } ld_exp_t;
    typedef struct { logic [63:0] dat; logic last; } wb_exp_t;
    ld_exp_t ld_q[$];
    wb_exp_t wb_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a load response is new when stall_hold was low at the capturing edge.
    bit          prev_stall = 1'b0;
    logic [63:0] last_rd = '0;
    bit          wb_hold = 1'b0;
    logic [63:0] hold_dat = '0;
    logic        hold_last = 1'b0;
    ld_exp_t     le;
    wb_exp_t     we_;

    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                if (!prev_stall) begin
                    if (ld_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ld_unexpected: got %h want no response", rdata);
                    end else begin
                        le = ld_q.pop_front();
                        total++;
                        if (le.neq ? (rdata === le.dat) : (rdata !== le.dat)) begin
                            bad++;
                            $display("FAIL ld_data: got %h want %s%h", rdata, le.neq ? "not " : "", le.dat);
                        end
                    end
                    last_rd = rdata;
                end else begin
                    chk("ld_hold", rdata, last_rd);
                end
            end
            if (wb_hold) begin
                chk("wb_hold_vld", wb_valid, 1);
                chk("wb_hold_dat", wb_data, hold_dat);
                chk("wb_hold_last", wb_last, hold_last);
            end
            if (wb_valid && wb_ready) begin
                if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: got %h want no beat", wb_data);
                end else begin
                    we_ = wb_q.pop_front();
                    chk("wb_dat", wb_data, we_.dat);
                    chk("wb_last", wb_last, we_.last);
                end
            end
            wb_hold   = wb_valid && !wb_ready;
            hold_dat  = wb_data;
            hold_last = wb_last;
        end
        prev_stall = stall_hold;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, input logic [1:0] h);
        req_valid = 1; req_we = 1; req_addr = a; req_wstrb = s; req_wdata = d; hit_way = h;
        tick();
        req_valid = 0; req_we = 0; hit_way = 0;
        if (!stall_hold) chk("store_rvalid", rdata_valid, 0);
    endtask

    task automatic load(input logic [63:0] a, input logic [1:0] h, input logic [63:0] e, input bit neq);
        req_valid = 1; req_we = 0; req_addr = a; hit_way = h;
        if (h != 0 && !stall_hold) ld_q.push_back('{e, neq});
        tick();
        req_valid = 0; hit_way = 0;
        if (h == 0) begin
            chk("miss_vld", rdata_valid, 0);
            chk("miss_dat", rdata, 0);
        end
    endtask

    task automatic refill(input logic [0:0] w, input logic [5:0] idx, input logic [63:0] base, input bit gap);
        refill_start = 1; refill_way = w; refill_index = idx;
        tick();
        refill_start = 0;
        chk("rf_ready", refill_ready, 1);
        chk("rf_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            refill_valid = 1; refill_data = base + 64'(i);
            tick();
            refill_valid = 0;
            chk("rf_done", refill_done, 64'(i == 3));
            if (gap && i < 3) begin
                tick();
                chk("rf_done_gap", refill_done, 0);
            end
        end
        chk("rf_exit", {busy, refill_ready}, 0);
        tick();
        chk("rf_done_pulse", refill_done, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit pat [6];
        pat = '{1, 0, 0, 1, 1, 1};
        #1 rst = 1;
        #2;
        chk("reset_ctl", {rdata_valid, busy, refill_ready, refill_done, wb_valid, wb_last}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_wbdata", wb_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();

        // Full store then load back.
        store(64'h48, 8'hFF, 64'h1122334455667788, 2'b01);
        load(64'h48, 2'b01, 64'h1122334455667788, 0);

        // Partial strobes, miss store, other way, multi-hit and miss loads.
        store(64'h48, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 2'b01);
        load(64'h48, 2'b01, 64'h11223344AAAAAAAA, 0);
        store(64'h48, 8'hFF, 64'hDEADBEEFDEADBEEF, 2'b00);
        load(64'h48, 2'b01, 64'h11223344AAAAAAAA, 0);
        load(64'h48, 2'b10, 64'h11223344AAAAAAAA, 1);
        load(64'h48, 2'b11, 64'h11223344AAAAAAAA, 0);
        load(64'h48, 2'b00, 64'h0, 0);

        // Gapped refill of way1 set 5, then read the line back.
        refill(1'b1, 6'd5, 64'hA0, 1);
        for (int w = 0; w < 4; w++) load(64'hA0 + 64'(8 * w), 2'b10, 64'hA0 + 64'(w), 0);

        // Writeback with a stalling consumer.
        for (int i = 0; i < 4; i++) wb_q.push_back('{64'hA0 + 64'(i), i == 3});
        wb_start = 1; wb_way = 1; wb_index = 5; wb_ready = 0;
        tick();
        wb_start = 0;
        for (int k = 0; k < 6; k++) begin
            wb_ready = pat[k];
            tick();
        end
        wb_ready = 0;
        chk("wb_end_busy", busy, 0);
        chk("wb_end_vld", wb_valid, 0);
        chk("wb_q_empty", wb_q.size(), 0);

        // Simultaneous starts: writeback wins, refill and loads are ignored while busy.
        for (int i = 0; i < 4; i++) wb_q.push_back('{64'hA0 + 64'(i), i == 3});
        wb_start = 1; refill_start = 1; wb_way = 1; wb_index = 5; refill_way = 0; refill_index = 0;
        tick();
        wb_start = 0; refill_start = 0;
        chk("both_busy", busy, 1);
        chk("both_rf_ready", refill_ready, 0);
        req_valid = 1; req_we = 0; req_addr = 64'h48; hit_way = 2'b01; refill_start = 1;
        tick();
        req_valid = 0; hit_way = 0; refill_start = 0;
        chk("busy_load_vld", rdata_valid, 0);
        wb_ready = 1;
        for (int k = 0; k < 10 && busy; k++) begin
            tick();
            chk("wb_rf_ready", refill_ready, 0);
        end
        wb_ready = 0;
        chk("both_end_busy", busy, 0);
        chk("both_wb_q_empty", wb_q.size(), 0);
        tick();
        chk("rf_dropped", {busy, refill_ready}, 0);

        // Reset in the middle of a refill, then a clean refill of the same line.
        refill_start = 1; refill_way = 0; refill_index = 7;
        tick();
        refill_start = 0;
        refill_valid = 1; refill_data = 64'hB0;
        tick();
        refill_data = 64'hB1;
        tick();
        refill_valid = 0;
        #2 rst = 1;
        #1;
        chk("midrst_ctl", {rdata_valid, busy, refill_ready, refill_done, wb_valid, wb_last}, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_wbdata", wb_data, 0);
        tick();
        rst = 0;
        tick();
        refill(1'b0, 6'd7, 64'hC0, 0);
        for (int w = 0; w < 4; w++) load(64'hE0 + 64'(8 * w), 2'b01, 64'hC0 + 64'(w), 0);

        // stall_hold freezes the response while stores still land in the array.
        load(64'hE0, 2'b01, 64'hC0, 0);
        stall_hold = 1;
        load(64'hE8, 2'b01, 64'h0, 0);
        store(64'hE8, 8'hFF, 64'h5555666677778888, 2'b01);
        stall_hold = 0;
        tick();
        tick();
        load(64'hE8, 2'b01, 64'h5555666677778888, 0);
        tick();
        tick();
        chk("ld_q_empty", ld_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
